// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared digit width, digit limits and clamp helper
package countdown_timer_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
   localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
   localparam logic [DIGIT_W-1:0] MINS_MAX = 4'd9;

   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val,
                                                      input logic [DIGIT_W-1:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// rtl/countdown_timer_bcd_down_digit.sv - one BCD down-counting digit with load and borrow
module bcd_down_digit
   import countdown_timer_pkg::*;
#(
   parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
   input  logic               clock,
   input  logic               clrn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               dec_en,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_out
);

   logic step;

   assign step       = dec_en & borrow_in;
   assign borrow_out = step & (q == '0);

   always_ff @(posedge clock) begin
      if (!clrn) begin
         q <= '0;
      end else if (load) begin
         q <= clamp_digit(load_val, MAX);
      end else if (step) begin
         // Wrapping to MAX on borrow is what chains the digits together.
         q <= (q == '0) ? MAX : q - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - M:SS BCD countdown timer with keypad shift-in load
module countdown_timer
   import countdown_timer_pkg::*;
(
   input  logic               clock,
   input  logic               clrn,
   input  logic [DIGIT_W-1:0] data,
   input  logic               loadn,
   input  logic               enable,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] mins,
   output logic               zero
);

   logic load;
   logic dec_en;
   logic ones_borrow;
   logic tens_borrow;
   logic unused_mins_borrow;

   assign zero   = (sec_ones == '0) && (sec_tens == '0) && (mins == '0);
   assign load   = ~loadn;
   // Gating on zero makes 0:00 sticky instead of wrapping to 9:59.
   assign dec_en = enable & loadn & ~zero;

   bcd_down_digit #(.MAX(ONES_MAX)) u_ones (
      .clock      (clock),
      .clrn       (clrn),
      .load       (load),
      .load_val   (data),
      .dec_en     (dec_en),
      .borrow_in  (1'b1),
      .q          (sec_ones),
      .borrow_out (ones_borrow)
   );

   bcd_down_digit #(.MAX(TENS_MAX)) u_tens (
      .clock      (clock),
      .clrn       (clrn),
      .load       (load),
      .load_val   (sec_ones),
      .dec_en     (dec_en),
      .borrow_in  (ones_borrow),
      .q          (sec_tens),
      .borrow_out (tens_borrow)
   );

   bcd_down_digit #(.MAX(MINS_MAX)) u_mins (
      .clock      (clock),
      .clrn       (clrn),
      .load       (load),
      .load_val   (sec_tens),
      .dec_en     (dec_en),
      .borrow_in  (tens_borrow),
      .q          (mins),
      .borrow_out (unused_mins_borrow)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - vector table plus randomized run against a seconds-based model
module tb_countdown_timer;

   logic       clock;
   logic       clrn;
   logic [3:0] data;
   logic       loadn;
   logic       enable;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] mins;
   logic       zero;

   int total = 0;
   int bad   = 0;

   countdown_timer dut (
      .clock    (clock),
      .clrn     (clrn),
      .data     (data),
      .loadn    (loadn),
      .enable   (enable),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .mins     (mins),
      .zero     (zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       clrn;
      logic       loadn;
      logic       enable;
      logic [3:0] data;
      int         reps;
      int         em;
      int         et;
      int         eo;
      string      name;
   } vec_t;

   vec_t vecs[$];

   // reference state kept as plain digits; counting goes through total seconds
   int m_m, m_t, m_o;

   task automatic add(input logic c, input logic l, input logic e, input int d, input int reps,
                      input int em, input int et, input int eo, input string name);
      vec_t v;
      v.clrn = c; v.loadn = l; v.enable = e; v.data = 4'(d); v.reps = reps;
      v.em = em; v.et = et; v.eo = eo; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic step(input logic c, input logic l, input logic e, input logic [3:0] d);
      clrn = c; loadn = l; enable = e; data = d;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input int em, input int et, input int eo);
      int ez;
      ez = (em == 0 && et == 0 && eo == 0) ? 1 : 0;
      total++;
      if (mins !== 4'(em) || sec_tens !== 4'(et) || sec_ones !== 4'(eo) || zero !== 1'(ez)) begin
         bad++;
         $display("FAIL %s: got %0d:%0d%0d zero=%0d, want %0d:%0d%0d zero=%0d",
                  name, mins, sec_tens, sec_ones, zero, em, et, eo, ez);
      end
   endtask

   task automatic model_edge(input logic c, input logic l, input logic e, input int d);
      int s;
      if (!c) begin
         m_m = 0; m_t = 0; m_o = 0;
      end else if (!l) begin
         m_m = m_t;
         m_t = (m_o > 5) ? 5 : m_o;
         m_o = (d > 9) ? 9 : d;
      end else if (e) begin
         s = m_m * 60 + m_t * 10 + m_o;
         if (s > 0) s = s - 1;
         m_m = s / 60;
         m_t = (s % 60) / 10;
         m_o = s % 10;
      end
   endtask

   initial begin
      clrn = 1'b0; loadn = 1'b1; enable = 1'b0; data = 4'd0;

      add(0, 1, 0, 0,  1, 0, 0, 0, "clear");
      add(1, 0, 0, 1,  1, 0, 0, 1, "load_d1");
      add(1, 0, 0, 1,  1, 0, 1, 1, "load_d2");
      add(1, 0, 0, 0,  1, 1, 1, 0, "load_1_10");
      add(1, 1, 1, 0,  1, 1, 0, 9, "count_1");
      add(1, 1, 1, 0, 10, 0, 5, 9, "count_11");
      add(1, 1, 1, 0, 59, 0, 0, 0, "count_70");
      add(1, 1, 1, 0,  5, 0, 0, 0, "count_75_nowrap");
      add(1, 0, 0, 0,  2, 0, 0, 0, "load_00");
      add(1, 0, 0, 5,  1, 0, 0, 5, "load_0_05");
      add(1, 1, 1, 0,  2, 0, 0, 3, "count_to_3");
      add(1, 1, 0, 0,  3, 0, 0, 3, "pause_hold");
      add(1, 1, 1, 0,  3, 0, 0, 0, "resume_zero");
      add(1, 0, 0, 7,  1, 0, 0, 7, "clamp_d7");
      add(1, 0, 0, 8,  1, 0, 5, 8, "clamp_d8");
      add(1, 0, 0, 15, 1, 5, 5, 9, "clamp_d15");
      add(1, 1, 1, 0, 60, 4, 5, 9, "minute_borrow");
      add(1, 0, 1, 3,  1, 5, 5, 3, "load_beats_enable");
      add(0, 0, 1, 4,  1, 0, 0, 0, "clear_beats_load");
      add(1, 0, 0, 3,  1, 0, 0, 3, "load_d3");
      add(1, 0, 0, 0,  1, 0, 3, 0, "load_0_30");
      add(1, 1, 1, 0,  4, 0, 2, 6, "count_0_26");
      add(0, 1, 1, 0,  1, 0, 0, 0, "mid_count_clear");
      add(1, 1, 1, 0,  3, 0, 0, 0, "after_clear_hold");

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++)
            step(vecs[i].clrn, vecs[i].loadn, vecs[i].enable, vecs[i].data);
         check(vecs[i].name, vecs[i].em, vecs[i].et, vecs[i].eo);
      end

      m_m = 0; m_t = 0; m_o = 0;
      for (int i = 0; i < 800; i++) begin
         logic c, l, e;
         logic [3:0] d;
         c = ($urandom_range(0, 59) != 0);
         l = ($urandom_range(0, 5) != 0);
         e = ($urandom_range(0, 3) != 0);
         d = 4'($urandom_range(0, 15));
         step(c, l, e, d);
         model_edge(c, l, e, int'(d));
         check("random", m_m, m_t, m_o);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
